// File: rtl/doorlock_param.sv
// Parametrised keypad door lock: configurable code/length, timed open window,
// failure counting with timed lockout. Optional entry timeout: DOORLOCK_TIMEOUT_EN.
module doorlock_param #(
  parameter int                       NBTN        = 10,
  parameter int                       MAX_LEN     = 8,
  parameter int                       CODE_LEN    = 3,
  parameter logic [4*MAX_LEN-1:0]     CODE        = 32'h0000_0721,
  parameter int                       OPEN_CYC    = 50_000_000,
  parameter int                       MAX_FAIL    = 3,
  parameter int                       LOCK_CYC    = 250_000_000,
  parameter int                       TIMEOUT_CYC = 500_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBTN-1:0]               bt,
  input  logic                          btstar,
  output logic                          led,
  output logic                          locked,
  output logic                          fail,
  output logic [$clog2(MAX_LEN+2)-1:0]  digit_cnt
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CW   = $clog2(MAX_LEN + 2);
  localparam int FW   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int TMAX = max_of(max_of(OPEN_CYC, LOCK_CYC), TIMEOUT_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_LOCK
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            led_q, led_d;
  logic            locked_q, locked_d;
  logic            fail_q, fail_d;

  // Press decode: any set bit is a press, more than one set bit is invalid.
  logic            press;
  logic            multi;
  logic [3:0]      digit;
  logic [4:0]      ones;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    ones  = '0;
    digit = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (bt[i]) begin
        ones  = ones + 5'd1;
        digit = 4'(i);
      end
    end
    press = (ones != '0);
    multi = (ones > 5'd1);
  end

  logic [4*MAX_LEN-1:0] code_sh;
  logic [3:0]           code_dig;
  logic                 dig_bad;
  logic                 pass;
  logic [FW-1:0]        fcnt_inc;

  always_comb begin
    code_sh  = CODE >> {cnt_q, 2'b00};
    code_dig = code_sh[3:0];
    dig_bad  = multi || (cnt_q >= CW'(CODE_LEN)) || (digit != code_dig);
    pass     = (cnt_q == CW'(CODE_LEN)) && !mis_q;
    fcnt_inc = (fcnt_q == FW'(MAX_FAIL)) ? fcnt_q : fcnt_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
      fcnt_q   <= '0;
      timer_q  <= '0;
      led_q    <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
      fcnt_q   <= fcnt_d;
      timer_q  <= timer_d;
      led_q    <= led_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    fcnt_d  = fcnt_q;
    timer_d = '0;

    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_ENTRY;
          cnt_d   = cnt_q + 1'b1;
          mis_d   = mis_q | dig_bad;
        end
      end

      S_ENTRY: begin
        if (btstar) begin
          state_d = S_CHECK;
        end else if (press) begin
          if (cnt_q != CW'(MAX_LEN + 1)) cnt_d = cnt_q + 1'b1;
          mis_d = mis_q | dig_bad;
        end
`ifdef DOORLOCK_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          mis_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end

      S_CHECK: begin
        cnt_d = '0;
        mis_d = 1'b0;
        if (pass) begin
          state_d = S_OPEN;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_inc;
          state_d = (fcnt_inc == FW'(MAX_FAIL)) ? S_LOCK : S_IDLE;
        end
      end

      S_OPEN: begin
        if (timer_q == TW'(OPEN_CYC - 1)) state_d = S_IDLE;
        else                              timer_d = timer_q + 1'b1;
      end

      S_LOCK: begin
        if (timer_q == TW'(LOCK_CYC - 1)) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are registered from the next state, so they align with the state flop.
  always_comb begin
    led_d    = (state_d == S_OPEN);
    locked_d = (state_d == S_LOCK);
    fail_d   = (state_q == S_ENTRY) && btstar && !pass;
  end

  assign led       = led_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_doorlock_param.sv
// Scoreboard bench for doorlock_param: stimulus queues expected fail/open/lock
// pulses (start cycle and width); a monitor measures each pulse and compares.
module tb_doorlock_param;

  typedef enum int {EV_FAIL = 0, EV_OPEN = 1, EV_LOCK = 2} ev_e;
  typedef struct {
    ev_e kind;
    int  at;
    int  len;
  } ev_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [9:0] bt     = '0;
  logic       btstar = 1'b0;
  logic       led;
  logic       locked;
  logic       fail;
  logic [3:0] digit_cnt;

  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  doorlock_param #(
    .OPEN_CYC   (4),
    .LOCK_CYC   (8),
    .TIMEOUT_CYC(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bt       (bt),
    .btstar   (btstar),
    .led      (led),
    .locked   (locked),
    .fail     (fail),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input ev_e kind, input int at, input int len);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Monitor: measures each high run of fail/led/locked and scores it on its fall.
  int         st[3];
  int         run[3];
  logic [2:0] prev = '0;

  task automatic emit(input int kind, input int at, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, int'(e.kind));
      check("ev_start_cycle", at, e.at);
      check("ev_width", len, e.len);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] now;
    now = {locked, led, fail};
    for (int k = 0; k < 3; k++) begin
      if (now[k] && !prev[k]) begin
        st[k]  = cyc;
        run[k] = 1;
      end else if (now[k]) begin
        run[k] = run[k] + 1;
      end else if (prev[k]) begin
        emit(k, st[k], run[k]);
      end
    end
    prev = now;
  end

  // Stimulus: drive just after a negedge; n is the edge that sampled the input.
  task automatic drive(input logic [9:0] b, input logic s, output int n);
    bt     = b;
    btstar = s;
    @(negedge clk);
    n      = cyc;
    bt     = '0;
    btstar = 1'b0;
  endtask

  task automatic key(input int d);
    int n;
    drive(10'b1 << d, 1'b0, n);
  endtask

  task automatic star(output int n);
    drive(10'b0, 1'b1, n);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic open_code();
    int n;
    key(1); key(2); key(7);
    star(n);
    expect_ev(EV_OPEN, n + 1, 4);
    idle(6);
  endtask

  initial begin
    int n;

    repeat (2) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail, 0);
    check("rst_digit_cnt", digit_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Correct code opens for exactly OPEN_CYC cycles, two edges after btstar.
    key(1); key(2); key(7);
    check("cnt_after_127", digit_cnt, 3);
    star(n);
    expect_ev(EV_OPEN, n + 1, 4);
    idle(6);
    check("cnt_after_open", digit_cnt, 0);

    // Wrong digit, then short code, then a third failure triggers lockout.
    key(1); key(2); key(5);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);
    key(1); key(2);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);
    key(3);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    expect_ev(EV_LOCK, n + 1, 8);
    key(1); key(2); key(7);
    star(n);
    check("locked_during_lockout", locked, 1);
    check("cnt_ignored_in_lockout", digit_cnt, 0);
    idle(5);
    check("locked_after_lockout", locked, 0);
    open_code();

    // Overlong code, then multi-hot press followed by the remaining digits.
    key(1); key(2); key(7); key(7);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);
    drive(10'h006, 1'b0, n);
    key(2); key(7);
    check("cnt_multihot_counts_one", digit_cnt, 3);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);
    open_code();

    // digit_cnt saturates at MAX_LEN+1.
    for (int i = 0; i < 10; i++) key(i);
    check("cnt_saturates", digit_cnt, 9);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);

    // btstar wins over a simultaneous digit press.
    key(1); key(2);
    drive(10'h080, 1'b1, n);
    expect_ev(EV_FAIL, n, 1);
    idle(2);

    // Reset during the open window closes the door at once and drops fail history.
    key(1); key(2); key(7);
    star(n);
    expect_ev(EV_OPEN, n + 1, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_open_led", led, 0);
    check("rst_mid_open_cnt", digit_cnt, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    open_code();
    key(9);
    star(n);
    expect_ev(EV_FAIL, n, 1);
    idle(10);
    check("no_lock_after_rst", locked, 0);

`ifdef DOORLOCK_TIMEOUT_EN
    // Inactivity in entry abandons the attempt without a failure.
    key(1); key(2);
    idle(5);
    check("timeout_clears_cnt", digit_cnt, 0);
    open_code();
`endif

    idle(4);
    check("expected_events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
